// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared pipeline types and address-map constants
package cpu_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } load_size_t;

  // Lowest I/O address; the EX-stage decode uses the same boundary.
  localparam logic [15:0] IO_BASE = 16'h3000;

  typedef struct packed {
    logic         valid;
    logic         mem_read;
    logic         reg_write;
    logic [31:0]  addr;
    load_size_t   size;
    logic         is_unsigned;
    logic         is_io;
    logic [31:0]  io_data;
  } memwb_t;

  function automatic load_size_t decode_size(input logic is_byte, input logic is_half);
    if (is_byte) return BYTE;
    if (is_half) return HALF;
    return WORD;
  endfunction

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - sub-word load alignment, extension and misalignment flag
module load_extend
  import cpu_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  low_addr,
  input  load_size_t  size,
  input  logic        is_unsigned,
  output logic [31:0] data,
  output logic        misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel   = raw[{low_addr, 3'b000} +: 8];
    // Halfword selection looks only at addr[1]; addr[0] just flags misalignment.
    half_sel   = low_addr[1] ? raw[31:16] : raw[15:0];
    data       = raw;
    misaligned = 1'b0;
    case (size)
      BYTE: begin
        data = is_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      end
      HALF: begin
        data       = is_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
        misaligned = low_addr[0];
      end
      default: begin
        data       = raw;
        misaligned = |low_addr;
      end
    endcase
  end

endmodule

// File: rtl/load_writeback.sv
// rtl/load_writeback.sv - MEM/WB register, read-data merge, stall hold buffer and writeback drive
module load_writeback #(
  parameter int          REG_AW  = 5,
  parameter logic [15:0] IO_BASE = cpu_pkg::IO_BASE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              WB_STALL,
  input  logic              EX_FLUSH,
  input  logic              ex_valid,
  input  logic              ex_memRead,
  input  logic              ex_regWrite,
  input  logic [REG_AW-1:0] ex_wa,
  input  logic [31:0]       ex_addr,
  input  logic              ex_isDMByte,
  input  logic              ex_isDMHalf,
  input  logic              ex_isUnsigned,
  input  logic [31:0]       DMout,
  input  logic [31:0]       PrRD,
  output logic              wb_valid,
  output logic              wb_regWrite,
  output logic [REG_AW-1:0] wb_wa,
  output logic [31:0]       wb_wd,
  output logic              wb_misaligned
);

  import cpu_pkg::*;

  memwb_t            r;
  logic [REG_AW-1:0] wa_q;
  logic              hold_valid;
  logic [31:0]       hold_data;
  logic [31:0]       raw_word;
  logic [31:0]       ext_data;
  logic              ext_misaligned;
  logic              keep;

  // A stall freezes the stage even if EX is flushed in the same cycle.
  assign keep = ~EX_FLUSH;

  always_ff @(posedge clk) begin
    if (reset) begin
      r    <= '0;
      wa_q <= '0;
    end else if (!WB_STALL) begin
      r.valid       <= ex_valid & keep;
      r.mem_read    <= ex_memRead & keep;
      r.reg_write   <= ex_regWrite & keep;
      r.addr        <= ex_addr;
      r.size        <= decode_size(ex_isDMByte, ex_isDMHalf);
      r.is_unsigned <= ex_isUnsigned;
      r.is_io       <= (ex_addr[15:0] >= IO_BASE);
      r.io_data     <= PrRD;
      wa_q          <= ex_wa;
    end
  end

  // The RAM word is only valid in the first WB cycle; keep it for the rest of a stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else if (WB_STALL && !hold_valid) begin
      hold_valid <= 1'b1;
      hold_data  <= DMout;
    end else if (!WB_STALL) begin
      hold_valid <= 1'b0;
    end
  end

  always_comb begin
    if (r.is_io)
      raw_word = r.io_data;
    else if (hold_valid)
      raw_word = hold_data;
    else
      raw_word = DMout;
  end

  load_extend u_load_extend (
    .raw         (raw_word),
    .low_addr    (r.addr[1:0]),
    .size        (r.size),
    .is_unsigned (r.is_unsigned),
    .data        (ext_data),
    .misaligned  (ext_misaligned)
  );

  assign wb_valid      = r.valid;
  assign wb_regWrite   = r.valid & r.reg_write & (wa_q != '0);
  assign wb_wa         = wa_q;
  assign wb_wd         = r.mem_read ? ext_data : r.addr;
  assign wb_misaligned = r.valid & r.mem_read & ext_misaligned;

endmodule

// File: tb/tb_load_writeback.sv
// tb/tb_load_writeback.sv - self-checking bench for load_writeback
module tb_load_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic        WB_STALL;
  logic        EX_FLUSH;
  logic        ex_valid;
  logic        ex_memRead;
  logic        ex_regWrite;
  logic [4:0]  ex_wa;
  logic [31:0] ex_addr;
  logic        ex_isDMByte;
  logic        ex_isDMHalf;
  logic        ex_isUnsigned;
  logic [31:0] DMout;
  logic [31:0] PrRD;
  logic        wb_valid;
  logic        wb_regWrite;
  logic [4:0]  wb_wa;
  logic [31:0] wb_wd;
  logic        wb_misaligned;

  int n_pass  = 0;
  int n_total = 0;

  load_writeback #(.REG_AW(5), .IO_BASE(16'h3000)) dut (
    .clk           (clk),
    .reset         (reset),
    .WB_STALL      (WB_STALL),
    .EX_FLUSH      (EX_FLUSH),
    .ex_valid      (ex_valid),
    .ex_memRead    (ex_memRead),
    .ex_regWrite   (ex_regWrite),
    .ex_wa         (ex_wa),
    .ex_addr       (ex_addr),
    .ex_isDMByte   (ex_isDMByte),
    .ex_isDMHalf   (ex_isDMHalf),
    .ex_isUnsigned (ex_isUnsigned),
    .DMout         (DMout),
    .PrRD          (PrRD),
    .wb_valid      (wb_valid),
    .wb_regWrite   (wb_regWrite),
    .wb_wa         (wb_wa),
    .wb_wd         (wb_wd),
    .wb_misaligned (wb_misaligned)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: value a load of the given size/extension returns from a 32-bit word.
  function automatic logic [31:0] model_load(input logic [31:0] raw, input logic [1:0] a,
                                             input bit by, input bit hf, input bit un);
    logic [31:0] v;
    if (by) begin
      v = (raw >> (8 * a)) & 32'hFF;
      if (!un && v >= 32'h80) v = v + 32'hFFFF_FF00;
    end else if (hf) begin
      v = (raw >> (16 * (a / 2))) & 32'hFFFF;
      if (!un && v >= 32'h8000) v = v + 32'hFFFF_0000;
    end else begin
      v = raw;
    end
    return v;
  endfunction

  function automatic bit model_misaligned(input logic [1:0] a, input bit by, input bit hf);
    if (by) return 1'b0;
    if (hf) return (a % 2) != 0;
    return a != 0;
  endfunction

  task automatic drive_ex(input bit v, input bit mr, input bit rw, input logic [4:0] wa,
                          input logic [31:0] addr, input bit by, input bit hf, input bit un,
                          input logic [31:0] prrd);
    ex_valid      = v;
    ex_memRead    = mr;
    ex_regWrite   = rw;
    ex_wa         = wa;
    ex_addr       = addr;
    ex_isDMByte   = by;
    ex_isDMHalf   = hf;
    ex_isUnsigned = un;
    PrRD          = prrd;
  endtask

  task automatic idle_ex();
    drive_ex(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  // Issues one instruction in EX, then presents dm as the RAM word in its WB cycle.
  task automatic issue_load(input logic [4:0] wa, input logic [31:0] addr, input bit by,
                            input bit hf, input bit un, input logic [31:0] prrd,
                            input logic [31:0] dm);
    @(negedge clk);
    drive_ex(1'b1, 1'b1, 1'b1, wa, addr, by, hf, un, prrd);
    @(posedge clk);
    #1;
    idle_ex();
    DMout = dm;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; WB_STALL = 1'b0; EX_FLUSH = 1'b0; DMout = 32'hDEAD_BEEF;
    drive_ex(1'b1, 1'b1, 1'b1, 5'd3, 32'h0000_1235, 1'b0, 1'b0, 1'b0, 32'h1111_2222);
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (wb_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", wb_valid); else n_pass++;
    n_total++; if (wb_regWrite !== 1'b0) $display("FAIL reset_regwrite: got %b want 0", wb_regWrite); else n_pass++;
    n_total++; if (wb_wa !== 5'd0) $display("FAIL reset_wa: got %0d want 0", wb_wa); else n_pass++;
    n_total++; if (wb_wd !== 32'h0) $display("FAIL reset_wd: got %h want 0", wb_wd); else n_pass++;
    n_total++; if (wb_misaligned !== 1'b0) $display("FAIL reset_misaligned: got %b want 0", wb_misaligned); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    idle_ex();
  endtask

  task automatic test_subword();
    issue_load(5'd4, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 32'h0, 32'h1234_80FF);
    n_total++; if (wb_wd !== 32'hFFFF_FF80) $display("FAIL lb_signed: got %h want ffffff80", wb_wd); else n_pass++;
    issue_load(5'd4, 32'h0000_0001, 1'b1, 1'b0, 1'b1, 32'h0, 32'h1234_80FF);
    n_total++; if (wb_wd !== 32'h0000_0080) $display("FAIL lbu: got %h want 00000080", wb_wd); else n_pass++;
    issue_load(5'd6, 32'h0000_0002, 1'b0, 1'b1, 1'b0, 32'h0, 32'h8001_7FFF);
    n_total++; if (wb_wd !== 32'hFFFF_8001) $display("FAIL lh_upper: got %h want ffff8001", wb_wd); else n_pass++;
    n_total++; if (wb_misaligned !== 1'b0) $display("FAIL lh_aligned_flag: got %b want 0", wb_misaligned); else n_pass++;
    issue_load(5'd6, 32'h0000_0001, 1'b0, 1'b1, 1'b0, 32'h0, 32'h8001_7FFF);
    n_total++; if (wb_misaligned !== 1'b1) $display("FAIL lh_misaligned: got %b want 1", wb_misaligned); else n_pass++;
    n_total++; if (wb_wd !== 32'h0000_7FFF) $display("FAIL lh_odd_data: got %h want 00007fff", wb_wd); else n_pass++;
  endtask

  task automatic test_io_load();
    issue_load(5'd8, 32'h0000_3004, 1'b0, 1'b0, 1'b0, 32'hCAFE_F00D, 32'h0);
    n_total++; if (wb_wd !== 32'hCAFE_F00D) $display("FAIL io_word: got %h want cafef00d", wb_wd); else n_pass++;
    n_total++; if (wb_regWrite !== 1'b1) $display("FAIL io_regwrite: got %b want 1", wb_regWrite); else n_pass++;
    issue_load(5'd8, 32'h0000_2FFC, 1'b0, 1'b0, 1'b0, 32'hCAFE_F00D, 32'h0BAD_0BAD);
    n_total++; if (wb_wd !== 32'h0BAD_0BAD) $display("FAIL dm_below_io_base: got %h want 0bad0bad", wb_wd); else n_pass++;
  endtask

  task automatic test_stall();
    @(negedge clk);
    drive_ex(1'b1, 1'b1, 1'b1, 5'd3, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    drive_ex(1'b1, 1'b0, 1'b1, 5'd7, 32'h0000_1234, 1'b0, 1'b0, 1'b0, 32'h0);
    DMout = 32'hAAAA_AAAA;
    WB_STALL = 1'b1;
    #1;
    n_total++; if (wb_wd !== 32'hAAAA_AAAA) $display("FAIL stall_first: got %h want aaaaaaaa", wb_wd); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      DMout = 32'h5555_5555;
      #1;
      n_total++; if (wb_wd !== 32'hAAAA_AAAA) $display("FAIL stall_hold_wd[%0d]: got %h want aaaaaaaa", i, wb_wd); else n_pass++;
      n_total++; if (wb_wa !== 5'd3) $display("FAIL stall_hold_wa[%0d]: got %0d want 3", i, wb_wa); else n_pass++;
    end
    WB_STALL = 1'b0;
    #1;
    n_total++; if (wb_wd !== 32'hAAAA_AAAA) $display("FAIL stall_release_pre: got %h want aaaaaaaa", wb_wd); else n_pass++;
    @(posedge clk);
    #1;
    n_total++; if (wb_wd !== 32'h0000_1234) $display("FAIL stall_release_wd: got %h want 00001234", wb_wd); else n_pass++;
    n_total++; if (wb_wa !== 5'd7) $display("FAIL stall_release_wa: got %0d want 7", wb_wa); else n_pass++;
    idle_ex();
    issue_load(5'd9, 32'h0000_0200, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0123_4567);
    n_total++; if (wb_wd !== 32'h0123_4567) $display("FAIL post_stall_direct: got %h want 01234567", wb_wd); else n_pass++;
  endtask

  task automatic test_flush();
    @(negedge clk);
    drive_ex(1'b1, 1'b0, 1'b1, 5'd5, 32'h0000_0042, 1'b0, 1'b0, 1'b0, 32'h0);
    EX_FLUSH = 1'b1;
    @(posedge clk);
    #1;
    EX_FLUSH = 1'b0;
    n_total++; if (wb_valid !== 1'b0) $display("FAIL flush_valid: got %b want 0", wb_valid); else n_pass++;
    n_total++; if (wb_regWrite !== 1'b0) $display("FAIL flush_regwrite: got %b want 0", wb_regWrite); else n_pass++;
    @(negedge clk);
    drive_ex(1'b1, 1'b0, 1'b1, 5'd9, 32'h0000_0055, 1'b0, 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    drive_ex(1'b1, 1'b0, 1'b1, 5'd5, 32'h0000_0066, 1'b0, 1'b0, 1'b0, 32'h0);
    EX_FLUSH = 1'b1;
    WB_STALL = 1'b1;
    @(posedge clk);
    #1;
    EX_FLUSH = 1'b0;
    WB_STALL = 1'b0;
    idle_ex();
    n_total++; if (wb_valid !== 1'b1) $display("FAIL flush_stall_valid: got %b want 1", wb_valid); else n_pass++;
    n_total++; if (wb_wa !== 5'd9) $display("FAIL flush_stall_wa: got %0d want 9", wb_wa); else n_pass++;
    n_total++; if (wb_wd !== 32'h0000_0055) $display("FAIL flush_stall_wd: got %h want 00000055", wb_wd); else n_pass++;
    n_total++; if (wb_regWrite !== 1'b1) $display("FAIL flush_stall_regwrite: got %b want 1", wb_regWrite); else n_pass++;
  endtask

  task automatic test_x0();
    @(negedge clk);
    drive_ex(1'b1, 1'b0, 1'b1, 5'd0, 32'h0000_0077, 1'b0, 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    idle_ex();
    n_total++; if (wb_valid !== 1'b1) $display("FAIL x0_valid: got %b want 1", wb_valid); else n_pass++;
    n_total++; if (wb_regWrite !== 1'b0) $display("FAIL x0_regwrite: got %b want 0", wb_regWrite); else n_pass++;
    n_total++; if (wb_wd !== 32'h0000_0077) $display("FAIL x0_wd: got %h want 00000077", wb_wd); else n_pass++;
  endtask

  task automatic test_reset_mid_stall();
    issue_load(5'd12, 32'h0000_0300, 1'b0, 1'b0, 1'b0, 32'h0, 32'hFEED_FACE);
    WB_STALL = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_total++; if (wb_valid !== 1'b0) $display("FAIL rst_stall_valid: got %b want 0", wb_valid); else n_pass++;
    n_total++; if (wb_regWrite !== 1'b0) $display("FAIL rst_stall_regwrite: got %b want 0", wb_regWrite); else n_pass++;
    n_total++; if (wb_wa !== 5'd0) $display("FAIL rst_stall_wa: got %0d want 0", wb_wa); else n_pass++;
    n_total++; if (wb_wd !== 32'h0) $display("FAIL rst_stall_wd: got %h want 0", wb_wd); else n_pass++;
    reset = 1'b0;
    WB_STALL = 1'b0;
    issue_load(5'd13, 32'h0000_0304, 1'b0, 1'b0, 1'b0, 32'h0, 32'h1357_9BDF);
    n_total++; if (wb_wd !== 32'h1357_9BDF) $display("FAIL rst_stall_hold_cleared: got %h want 13579bdf", wb_wd); else n_pass++;
  endtask

  task automatic test_random();
    bit          v, mr, rw, by, hf, un, fl, io;
    logic [4:0]  wa;
    logic [31:0] addr, prrd, dm, raw, exp_wd;
    bit          exp_v, exp_rw, exp_mis;
    int          sz;
    for (int i = 0; i < 60; i++) begin
      v  = ($urandom_range(0, 5) != 0);
      mr = $urandom_range(0, 1);
      rw = $urandom_range(0, 1);
      fl = ($urandom_range(0, 7) == 0);
      un = $urandom_range(0, 1);
      sz = $urandom_range(0, 2);
      by = (sz == 0);
      hf = (sz == 1);
      wa = 5'($urandom_range(0, 31));
      addr = $urandom;
      if ($urandom_range(0, 1) == 1) addr[15:0] = 16'($urandom_range(0, 16'h2FFF));
      else addr[15:0] = 16'($urandom_range(16'h3000, 16'hFFFF));
      prrd = $urandom;
      dm   = $urandom;
      @(negedge clk);
      drive_ex(v, mr, rw, wa, addr, by, hf, un, prrd);
      EX_FLUSH = fl;
      @(posedge clk);
      #1;
      EX_FLUSH = 1'b0;
      idle_ex();
      DMout = dm;
      #1;
      io      = (addr % 65536) >= 32'h3000;
      raw     = io ? prrd : dm;
      exp_v   = v && !fl;
      exp_rw  = exp_v && rw && (wa != 0);
      exp_wd  = mr ? model_load(raw, addr[1:0], by, hf, un) : addr;
      exp_mis = exp_v && mr && model_misaligned(addr[1:0], by, hf);
      n_total++; if (wb_valid !== exp_v) $display("FAIL rnd_valid[%0d]: got %b want %b", i, wb_valid, exp_v); else n_pass++;
      n_total++; if (wb_regWrite !== exp_rw) $display("FAIL rnd_regwrite[%0d]: got %b want %b", i, wb_regWrite, exp_rw); else n_pass++;
      n_total++; if (wb_misaligned !== exp_mis) $display("FAIL rnd_misaligned[%0d]: got %b want %b", i, wb_misaligned, exp_mis); else n_pass++;
      if (exp_v) begin
        n_total++; if (wb_wa !== wa) $display("FAIL rnd_wa[%0d]: got %0d want %0d", i, wb_wa, wa); else n_pass++;
        n_total++; if (wb_wd !== exp_wd) $display("FAIL rnd_wd[%0d]: got %h want %h", i, wb_wd, exp_wd); else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_subword();
    test_io_load();
    test_stall();
    test_flush();
    test_x0();
    test_reset_mid_stall();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
